// File: rtl/pattern_match_pkg.sv
// Shared defaults and configuration record for the serial pattern detector.
package pattern_match_pkg;

   localparam int PM_WIDTH_DEF = 8;
   localparam int PM_CNT_W_DEF = 8;
   localparam int PM_MAX_W     = 32;
   localparam logic [7:0] PM_PAT_RESET_DEF = 8'b1101_0110;

   // Configuration record; fields sized for the widest legal window and
   // zero-extended, so unused upper mask bits never take part in a compare.
   typedef struct packed {
      logic [PM_MAX_W-1:0] pattern;
      logic [PM_MAX_W-1:0] mask;
      logic                overlap;
   } pm_cfg_t;

   // Resize the 8-bit default pattern to w bits. The first-received bits
   // are kept: narrower windows take the MSBs, wider ones pad with zeros
   // after the default.
   function automatic logic [PM_MAX_W-1:0] pm_resize_pat(input int w);
      logic [PM_MAX_W-1:0] p;
      p = PM_MAX_W'(PM_PAT_RESET_DEF);
      if (w <= 8) return p >> (8 - w);
      else        return p << (w - 8);
   endfunction

endpackage

// File: rtl/pattern_match_n_sat_counter.sv
// Clear-priority saturating event counter.
module pm_sat_counter
   import pattern_match_pkg::*;
#(
   parameter int CNT_W = PM_CNT_W_DEF
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   assign sat = &count;

   // Clear wins over increment; hold once all-ones is reached.
   always_ff @(posedge clock) begin
      if (!rst_n)          count <= '0;
      else if (clr)        count <= '0;
      else if (inc && !sat) count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pattern_match_n.sv
// Serial sliding-window pattern detector with don't-care mask,
// overlap/non-overlap modes and a saturating hit counter.
module pattern_match_n
   import pattern_match_pkg::*;
#(
   parameter int               WIDTH     = PM_WIDTH_DEF,
   parameter int               CNT_W     = PM_CNT_W_DEF,
   parameter logic [WIDTH-1:0] PAT_RESET = WIDTH'(pm_resize_pat(WIDTH))
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             ser_in,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] pattern,
   input  logic [WIDTH-1:0] mask,
   input  logic             overlap,
   input  logic             clr_count,
   output logic             found,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int FILL_W = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

   logic [WIDTH-1:0]  win;
   logic [FILL_W-1:0] fill;
   pm_cfg_t           cfg_r;
   logic              restart;

   // Match is purely from registered state; masked-off bits always agree.
   assign found   = (fill == FILL_FULL) &&
                    (((PM_MAX_W'(win) ^ cfg_r.pattern) & cfg_r.mask) == '0);
   // Non-overlap flush or reconfiguration starts a fresh window.
   assign restart = (found && !cfg_r.overlap) || cfg_load;

   // Window shift, fill tracking and configuration registers.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         win           <= '0;
         fill          <= '0;
         cfg_r.pattern <= PM_MAX_W'(PAT_RESET);
         cfg_r.mask    <= PM_MAX_W'({WIDTH{1'b1}});
         cfg_r.overlap <= 1'b1;
      end else begin
         win <= {win[WIDTH-2:0], ser_in};
         // The bit sampled on a restart edge is the first of the new window.
         if (restart)                fill <= FILL_W'(1);
         else if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
         if (cfg_load) begin
            cfg_r.pattern <= PM_MAX_W'(pattern);
            cfg_r.mask    <= PM_MAX_W'(mask);
            cfg_r.overlap <= overlap;
         end
      end
   end

   pm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .rst_n (rst_n),
      .inc   (found),
      .clr   (clr_count),
      .count (match_count),
      .sat   (count_sat)
   );

endmodule

// File: tb/tb_pattern_match_n.sv
// Directed bench for pattern_match_n at WIDTH=4, CNT_W=3. Expected found
// values are queued as each bit is driven and popped after the edge.
module tb_pattern_match_n;

   localparam int W  = 4;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          ser_in = 1'b0;
   logic          cfg_load = 1'b0;
   logic [W-1:0]  pattern = '0;
   logic [W-1:0]  mask = '0;
   logic          overlap = 1'b0;
   logic          clr_count = 1'b0;
   logic          found;
   logic [CW-1:0] match_count;
   logic          count_sat;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];

   pattern_match_n #(.WIDTH(W), .CNT_W(CW)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .ser_in      (ser_in),
      .cfg_load    (cfg_load),
      .pattern     (pattern),
      .mask        (mask),
      .overlap     (overlap),
      .clr_count   (clr_count),
      .found       (found),
      .match_count (match_count),
      .count_sat   (count_sat)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one bit, queue the expected found for the cycle after the edge,
   // then pop and compare once the edge has passed.
   task automatic step(input logic b, input logic exp_found, input string tag);
      logic e;
      ser_in = b;
      exp_q.push_back(exp_found);
      @(posedge clock);
      #1;
      cfg_load  = 1'b0;
      clr_count = 1'b0;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 32'(found), 32'(e));
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      ser_in = 1'b0;
      @(posedge clock);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [W-1:0] p, input logic [W-1:0] m, input logic o);
      pattern   = p;
      mask      = m;
      overlap   = o;
      cfg_load  = 1'b1;
      clr_count = 1'b1;
   endtask

   initial begin
      // 1. Reset pattern 1101
      do_reset();
      chk("rst_found", 32'(found), 0);
      chk("rst_count", 32'(match_count), 0);
      chk("rst_sat", 32'(count_sat), 0);
      chk("rst_fill", 32'(dut.fill), 0);
      step(1, 0, "s1_b1"); step(1, 0, "s1_b2"); step(0, 0, "s1_b3");
      step(1, 1, "s1_b4"); step(0, 0, "s1_b5");
      chk("s1_count", 32'(match_count), 1);
      step(1, 0, "s1_b6"); step(1, 0, "s1_b7"); step(0, 0, "s1_b8");
      step(1, 1, "s1_b9");
      // Reset while matching: 3 fresh bits never fire
      do_reset();
      chk("s1_rst_found", 32'(found), 0);
      step(1, 0, "s1_r1"); step(1, 0, "s1_r2"); step(0, 0, "s1_r3");
      step(1, 1, "s1_r4");

      // 2. Overlap: 1010 found after bits 4 and 6
      load(4'b1010, 4'b1111, 1'b1);
      step(1, 0, "s2_b1"); step(0, 0, "s2_b2"); step(1, 0, "s2_b3");
      step(0, 1, "s2_b4"); step(1, 0, "s2_b5"); step(0, 1, "s2_b6");
      step(0, 0, "s2_b7");
      chk("s2_count", 32'(match_count), 2);

      // 3. Non-overlap: found after bits 4 and 8 only
      load(4'b1010, 4'b1111, 1'b0);
      step(1, 0, "s3_b1"); step(0, 0, "s3_b2"); step(1, 0, "s3_b3");
      step(0, 1, "s3_b4"); step(1, 0, "s3_b5"); step(0, 0, "s3_b6");
      step(1, 0, "s3_b7"); step(0, 1, "s3_b8"); step(0, 0, "s3_b9");
      chk("s3_count", 32'(match_count), 2);

      // 4. Don't-care mask 1001 against pattern 1001
      load(4'b1001, 4'b1001, 1'b0);
      step(1, 0, "s4_b1"); step(1, 0, "s4_b2"); step(1, 0, "s4_b3");
      step(1, 1, "s4_b4"); step(1, 0, "s4_b5"); step(0, 0, "s4_b6");
      step(0, 0, "s4_b7"); step(1, 1, "s4_b8"); step(0, 0, "s4_b9");

      // 5. All don't-care, overlap: count saturates at 7
      load(4'b0000, 4'b0000, 1'b1);
      for (int i = 1; i <= 12; i++) begin
         step(i[0], (i >= 4), "s5_found");
         chk("s5_count", 32'(match_count), (i <= 4) ? 0 : ((i - 4 > 7) ? 7 : i - 4));
      end
      chk("s5_sat", 32'(count_sat), 1);
      clr_count = 1'b1;
      step(0, 1, "s5_clr_found");
      chk("s5_clr_count", 32'(match_count), 0);
      chk("s5_clr_sat", 32'(count_sat), 0);
      step(1, 1, "s5_post_found");
      chk("s5_post_count", 32'(match_count), 1);

      // 6. cfg_load while found=1: hit counted, window restarts
      pattern  = 4'b0000;
      mask     = 4'b0000;
      overlap  = 1'b1;
      cfg_load = 1'b1;
      step(1, 0, "s6_cfg_e1");
      chk("s6_cfg_count", 32'(match_count), 2);
      step(0, 0, "s6_cfg_e2"); step(1, 0, "s6_cfg_e3");
      step(1, 1, "s6_cfg_e4");
      chk("s6_hold_count", 32'(match_count), 2);
      // Reset while found=1
      do_reset();
      chk("s6_rst_found", 32'(found), 0);
      chk("s6_rst_count", 32'(match_count), 0);
      chk("s6_rst_fill", 32'(dut.fill), 0);
      // Configuration is back to 1101 / all-ones mask
      step(1, 0, "s6_r1"); step(1, 0, "s6_r2"); step(0, 0, "s6_r3");
      step(1, 1, "s6_r4"); step(1, 0, "s6_r5");
      chk("s6_final_count", 32'(match_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
